spi_master_ctrl: RTL and testbench

//  SPI mode-0 initiator for our register-access protocol. Issues one {rw,addr} command byte

---
 rtl/spi_master_pkg.sv | 28 ++
 rtl/spi_master_clkgen.sv | 40 ++++
 rtl/spi_master_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI register-access initiator.
// Frame layout (MSB first): {rw, addr[6:0], data[7:0]}; rw=1 is a read.
package spi_master_pkg;

    // Frame sequencer states, in the order a frame walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Field widths at the default configuration.
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_BITS   = 1 + ADDR_W;            // command byte {rw, addr}
    localparam int FRAME_BITS = CMD_BITS + DATA_W;     // 16
    localparam int RW_BIT     = FRAME_BITS - 1;        // 15

    // Largest of three values; sizes the shared SETUP/HOLD/GAP wait counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCLK timing generator: while enabled, emits single-cycle rise_en/fall_en
// strobes alternately every CLK_DIV clk cycles, starting with a rise after
// CLK_DIV low cycles. Disabling returns it to the SCLK-low phase.
module spi_master_clkgen
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic rise_en,
    output logic fall_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             sclk_high;
    logic             half_done;

    assign half_done = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_en   = half_done && !sclk_high;
    assign fall_en   = half_done &&  sclk_high;

    // Half-period counter and current SCLK phase.
    // NOTE: reset here is synchronous -- reset_n is only looked at on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            div_cnt   <= '0;
            sclk_high <= 1'b0;
        end else if (half_done) begin
            div_cnt   <= '0;
            sclk_high <= ~sclk_high;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator for the register-access protocol: one CS frame carries
// {rw, addr} then one data byte, MSB first; the data-phase MISO byte is returned.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to let cfg_loopback feed the
// internal MOSI back into the sampler instead of spi_miso.
module spi_master_ctrl
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int ADDR_BITS = ADDR_W,
    parameter int DATA_BITS = DATA_W,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_GAP    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [DATA_BITS-1:0] req_wdata,
    input  logic                 cfg_loopback,
    output logic                 resp_valid,
    output logic [DATA_BITS-1:0] resp_rdata,
    output logic                 busy,
    output logic                 spi_cs0,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int FRAME_W = 1 + ADDR_BITS + DATA_BITS;
    localparam int CMD_W   = 1 + ADDR_BITS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int WAIT_W  = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

    state_t               state;
    state_t               state_nxt;
    logic [FRAME_W-1:0]   tx_sreg;
    logic [DATA_BITS-1:0] rx_sreg;
    logic [BIT_W-1:0]     bit_cnt;
    logic [WAIT_W-1:0]    wait_cnt;
    logic                 rise_en;
    logic                 fall_en;
    logic                 accept;
    logic                 frame_done;
    logic                 cs0_nxt;
    logic                 wait_run;
    logic                 data_phase;
    logic                 sample_bit;

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign spi_mosi   = tx_sreg[FRAME_W-1];
    assign data_phase = (bit_cnt >= BIT_W'(CMD_W));

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = cfg_loopback ? spi_mosi : spi_miso;
`else
    // cfg_loopback has no effect in this build.
    logic unused_cfg_loopback;
    assign unused_cfg_loopback = cfg_loopback;
    assign sample_bit          = spi_miso;
`endif

    spi_master_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (state == ST_SHIFT),
        .rise_en (rise_en),
        .fall_en (fall_en)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-cycle strobes that steer the datapath.
    // NOTE: every output gets a default first so no path leaves a value held (no latches).
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        frame_done = 1'b0;
        wait_run   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                wait_run = 1'b1;
                if (wait_cnt == WAIT_W'(CS_SETUP - 1)) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (fall_en && (bit_cnt == BIT_W'(FRAME_W - 1))) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                wait_run = 1'b1;
                if (wait_cnt == WAIT_W'(CS_HOLD - 1)) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_GAP;
                end
            end
            ST_GAP: begin
                wait_run = 1'b1;
                if (wait_cnt == WAIT_W'(CS_GAP - 1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        cs0_nxt = !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT) || (state_nxt == ST_HOLD));
    end

    // Registered pin drivers, shift registers, counters and the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sreg    <= '0;
            rx_sreg    <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            spi_cs0    <= 1'b1;
            spi_clk    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            spi_cs0    <= cs0_nxt;
            resp_valid <= frame_done;

            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (wait_run) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // MOSI presents bit 15 from CS low onwards and advances on each SCLK fall.
            if (accept) begin
                tx_sreg <= {req_rw, req_addr, req_wdata};
                bit_cnt <= '0;
            end else if (fall_en) begin
                tx_sreg <= {tx_sreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end

            // MISO is sampled on the edge that raises SCLK; only data-phase bits are kept.
            if (rise_en) begin
                spi_clk <= 1'b1;
                if (data_phase) rx_sreg <= {rx_sreg[DATA_BITS-2:0], sample_bit};
            end else if (fall_en) begin
                spi_clk <= 1'b0;
            end

            if (frame_done) resp_rdata <= rx_sreg;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: table of single frames, plus
// back-to-back, mid-frame reset, loopback and a CLK_DIV=2 instance.
`timescale 1ns/1ps
module tb_spi_master_ctrl;
    import spi_master_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // Main instance (default parameters)
    logic       req_valid = 1'b0;
    logic       req_rw = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       cfg_loopback = 1'b0;
    logic       req_ready, resp_valid, busy, spi_cs0, spi_clk, spi_mosi, spi_miso;
    logic [7:0] resp_rdata;

    // Fast instance (CLK_DIV=2)
    logic       req_valid2 = 1'b0;
    logic       req_ready2, resp_valid2, busy2, spi_cs0_2, spi_clk2, spi_mosi2;
    logic [7:0] resp_rdata2;

    always #5 clk = ~clk;

    spi_master_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .cfg_loopback(cfg_loopback), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .busy(busy), .spi_cs0(spi_cs0), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    spi_master_ctrl #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .cfg_loopback(1'b0), .resp_valid(resp_valid2), .resp_rdata(resp_rdata2),
        .busy(busy2), .spi_cs0(spi_cs0_2), .spi_clk(spi_clk2), .spi_mosi(spi_mosi2),
        .spi_miso(1'b0)
    );

`ifdef SPI_MASTER_LOOPBACK_EN
    localparam logic [7:0] LB_EXP = 8'h5A;
`else
    localparam logic [7:0] LB_EXP = 8'hFF;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Bus monitor (both instances) and mode-0 slave model (main instance only)
    logic [1:0] cs_w, sclk_w, mosi_w, rv_w;
    assign cs_w   = {spi_cs0_2, spi_cs0};
    assign sclk_w = {spi_clk2, spi_clk};
    assign mosi_w = {spi_mosi2, spi_mosi};
    assign rv_w   = {resp_valid2, resp_valid};

    logic [1:0] prev_cs = 2'b11;
    logic [1:0] prev_sclk = 2'b00;
    int cyc = 0;
    int cs_low_f[2], rises_f[2], first_rise_at[2], period_f[2], last_fall_at[2];
    int cs_rise_at[2], cs_fall_at[2], gap_f[2], setup_f[2], rv_cnt[2], sclk_bad[2];
    logic [FRAME_BITS-1:0] mosi_cap[2];
    logic [FRAME_BITS-1:0] slave_word = '0;
    logic [FRAME_BITS-1:0] slave_sh = '0;
    assign spi_miso = slave_sh[RW_BIT];

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_w[i]) begin
                cs_fall_at[i] = cyc;
                gap_f[i]      = cyc - cs_rise_at[i];
                cs_low_f[i]   = 0;
                rises_f[i]    = 0;
                mosi_cap[i]   = '0;
                if (i == 0) slave_sh = slave_word;
            end
            if (!prev_cs[i] && cs_w[i]) cs_rise_at[i] = cyc;
            if (!cs_w[i]) cs_low_f[i]++;
            if (!prev_sclk[i] && sclk_w[i]) begin
                rises_f[i]++;
                mosi_cap[i] = {mosi_cap[i][FRAME_BITS-2:0], mosi_w[i]};
                if (rises_f[i] == 1) begin
                    first_rise_at[i] = cyc;
                    setup_f[i]       = cyc - cs_fall_at[i];
                end else if (rises_f[i] == 2) begin
                    period_f[i] = cyc - first_rise_at[i];
                end
            end
            if (prev_sclk[i] && !sclk_w[i]) begin
                last_fall_at[i] = cyc;
                if (i == 0 && !cs_w[0]) slave_sh = {slave_sh[FRAME_BITS-2:0], 1'b0};
            end
            if (cs_w[i] && sclk_w[i]) sclk_bad[i]++;
            if (rv_w[i]) rv_cnt[i]++;
        end
        prev_cs   = cs_w;
        prev_sclk = sclk_w;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next falling clk edge (outputs stable there).
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 300 && !req_ready; k++) tick();
        check("wait req_ready", req_ready, 1'b1);
    endtask

    task automatic wait_resp();
        for (int k = 0; k < 400 && !resp_valid; k++) tick();
        check("wait resp_valid", resp_valid, 1'b1);
    endtask

    typedef struct {
        logic                  rw;
        logic [6:0]            addr;
        logic [7:0]            wdata;
        logic [7:0]            slave;
        logic [FRAME_BITS-1:0] exp_mosi;
        logic [7:0]            exp_rdata;
    } vec_t;

    vec_t vecs[5];
    int   rv0;

    // One frame from a vector: MOSI word, captured byte and frame timing.
    task automatic run_vec(input vec_t v, input int idx);
        wait_ready();
        rv0        = rv_cnt[0];
        slave_word = {~v.slave, v.slave};
        req_rw     = v.rw;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_rw     = ~v.rw;
        req_addr   = ~v.addr;
        req_wdata  = ~v.wdata;
        check($sformatf("v%0d cs low 1 clk after accept", idx), spi_cs0, 1'b0);
        check($sformatf("v%0d busy", idx), busy, 1'b1);
        wait_resp();
        check($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d mosi word", idx), mosi_cap[0], v.exp_mosi);
        check($sformatf("v%0d cs low cycles", idx), cs_low_f[0], 132);
        check($sformatf("v%0d sclk rises", idx), rises_f[0], 16);
        check($sformatf("v%0d cs to first rise", idx), setup_f[0], 6);
        check($sformatf("v%0d last fall to cs high", idx), cs_rise_at[0] - last_fall_at[0], 2);
        tick();
        check($sformatf("v%0d resp_valid one cycle", idx), resp_valid, 1'b0);
        check($sformatf("v%0d resp_valid count", idx), rv_cnt[0] - rv0, 1);
    endtask

    initial begin
        vecs[0] = '{rw: 1'b0, addr: 7'h12, wdata: 8'hA5, slave: 8'h5C, exp_mosi: 16'h12A5, exp_rdata: 8'h5C};
        vecs[1] = '{rw: 1'b1, addr: 7'h11, wdata: 8'h00, slave: 8'h3C, exp_mosi: 16'h9100, exp_rdata: 8'h3C};
        vecs[2] = '{rw: 1'b0, addr: 7'h7F, wdata: 8'hFF, slave: 8'h81, exp_mosi: 16'h7FFF, exp_rdata: 8'h81};
        vecs[3] = '{rw: 1'b1, addr: 7'h00, wdata: 8'h01, slave: 8'hC3, exp_mosi: 16'h8001, exp_rdata: 8'hC3};
        vecs[4] = '{rw: 1'b1, addr: 7'h55, wdata: 8'hAA, slave: 8'h00, exp_mosi: 16'hD5AA, exp_rdata: 8'h00};

        // Reset state
        reset_n = 1'b0;
        repeat (3) tick();
        check("reset spi_cs0", spi_cs0, 1'b1);
        check("reset spi_clk", spi_clk, 1'b0);
        check("reset spi_mosi", spi_mosi, 1'b0);
        check("reset req_ready", req_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset resp_valid", resp_valid, 1'b0);
        check("reset resp_rdata", resp_rdata, 8'h00);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Back-to-back: req_valid held high across two requests
        wait_ready();
        slave_word = 16'hFF00;
        req_rw     = 1'b0;
        req_addr   = 7'h33;
        req_wdata  = 8'h0F;
        req_valid  = 1'b1;
        tick();
        req_rw     = 1'b1;
        req_addr   = 7'h44;
        req_wdata  = 8'hF0;
        slave_word = 16'h6996;
        wait_resp();
        check("b2b first mosi word", mosi_cap[0], 16'h330F);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b2b req_ready low gap cycle %0d", k), req_ready, 1'b0);
            tick();
        end
        check("b2b req_ready after gap", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("b2b cs high cycles between frames", gap_f[0], 5);
        check("b2b second frame started", spi_cs0, 1'b0);
        wait_resp();
        check("b2b second mosi word", mosi_cap[0], 16'hC4F0);
        check("b2b second rdata", resp_rdata, 8'h96);

        // Reset in the middle of bit 5
        wait_ready();
        rv0        = rv_cnt[0];
        slave_word = 16'h00FF;
        req_rw     = 1'b1;
        req_addr   = 7'h2A;
        req_wdata  = 8'h00;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 200 && rises_f[0] < 6; k++) tick();
        check("rst reached bit 5", rises_f[0], 6);
        check("rst frame active", spi_cs0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst spi_cs0", spi_cs0, 1'b1);
        check("rst spi_clk", spi_clk, 1'b0);
        check("rst resp_rdata cleared", resp_rdata, 8'h00);
        check("rst resp_valid", resp_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("rst no resp_valid", rv_cnt[0] - rv0, 0);
        check("rst stays idle", spi_cs0, 1'b1);

        // Loopback select (result depends on build)
        wait_ready();
        slave_word   = 16'hFFFF;
        cfg_loopback = 1'b1;
        req_rw       = 1'b1;
        req_addr     = 7'h22;
        req_wdata    = 8'h5A;
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_resp();
        check("loopback rdata", resp_rdata, LB_EXP);
        check("loopback mosi word", mosi_cap[0], 16'hA25A);
        cfg_loopback = 1'b0;

        // CLK_DIV=2 instance
        for (int k = 0; k < 300 && !req_ready2; k++) tick();
        check("div2 wait req_ready", req_ready2, 1'b1);
        req_rw     = 1'b0;
        req_addr   = 7'h0C;
        req_wdata  = 8'h3E;
        req_valid2 = 1'b1;
        tick();
        req_valid2 = 1'b0;
        for (int k = 0; k < 300 && !resp_valid2; k++) tick();
        check("div2 wait resp_valid", resp_valid2, 1'b1);
        check("div2 sclk rises", rises_f[1], 16);
        check("div2 sclk period", period_f[1], 4);
        check("div2 cs low cycles", cs_low_f[1], 68);
        check("div2 cs to first rise", setup_f[1], 4);
        check("div2 last fall to cs high", cs_rise_at[1] - last_fall_at[1], 2);
        check("div2 mosi word", mosi_cap[1], 16'h0C3E);
        check("div2 sclk high while cs high", sclk_bad[1], 0);
        check("sclk high while cs high", sclk_bad[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
